// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing, baud helpers.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 9600;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;
`endif

    function automatic int calc_baud_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_cnt_width(input int baud_cnt);
        return (baud_cnt < 2) ? 1 : $clog2(baud_cnt);
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready handshake feeding the UART transmitter.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..BAUD_CNT-1 while enabled, ticks on the last count.
module uart_baud_cnt #(
    parameter int BAUD_CNT = 5208,
    parameter int CNT_W    = $clog2(BAUD_CNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Tick is decoded from the count so the FSM moves on the last clock of a bit.
    always_comb begin
        tick = en && (cnt_r == CNT_MAX);
    end

    // Counter register, cleared on request and on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (tick) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, 8N1 LSB-first frame out on tx_uart.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave tx,
    output logic     tx_uart,
    output logic     busy
);
    localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD);
    localparam int CNT_W    = calc_cnt_width(BAUD_CNT);

    uart_state_t state_r;
    uart_state_t state_next_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_next_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_cnt_next_s;
    logic        tx_uart_r;
    logic        tx_ready_r;
    logic        busy_r;
    logic        tx_uart_s;
    logic        tx_ready_s;
    logic        busy_s;
    logic        accept_s;
    logic        tick_s;
    logic        baud_en_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
    logic        parity_next_s;
`endif

    assign accept_s    = tx.tx_valid && tx_ready_r;
    assign baud_en_s   = (state_r != IDLE);
    assign tx.tx_ready = tx_ready_r;
    assign tx_uart     = tx_uart_r;
    assign busy        = busy_r;

    uart_baud_cnt #(
        .BAUD_CNT (BAUD_CNT),
        .CNT_W    (CNT_W)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (baud_en_s),
        .clr  (accept_s),
        .tick (tick_s)
    );

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            tx_uart_r  <= 1'b1;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_next_s;
            shift_r    <= shift_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            tx_uart_r  <= tx_uart_s;
            tx_ready_r <= tx_ready_s;
            busy_r     <= busy_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_next_s;
`endif
        end
    end

    // Next-state logic: every non-idle state lasts whole bit periods.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s && (bit_cnt_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Shift register and bit counter: load on accept, advance at each data-bit end.
    always_comb begin
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
`ifdef UART_TX_PARITY_EN
        parity_next_s  = parity_r;
`endif
        if (accept_s) begin
            shift_next_s   = tx.tx_data;
            bit_cnt_next_s = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_next_s  = even_parity(tx.tx_data);
`endif
        end else if ((state_r == DATA) && tick_s) begin
            shift_next_s   = {1'b0, shift_r[7:1]};
            bit_cnt_next_s = bit_cnt_r + 3'd1;
        end else begin
            shift_next_s   = shift_r;
            bit_cnt_next_s = bit_cnt_r;
        end
    end

    // Outputs decoded from the upcoming state so the registered line changes on bit boundaries.
    always_comb begin
        tx_uart_s  = 1'b1;
        tx_ready_s = 1'b0;
        busy_s     = 1'b0;
        case (state_next_s)
            IDLE: begin
                tx_uart_s  = 1'b1;
                tx_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            START: begin
                tx_uart_s  = 1'b0;
                tx_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            DATA: begin
                tx_uart_s  = shift_next_s[0];
                tx_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_uart_s  = parity_r;
                tx_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
`endif
            STOP: begin
                tx_uart_s  = 1'b1;
                tx_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            default: begin
                tx_uart_s  = 1'b1;
                tx_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

endmodule
